// File: rtl/add_shift_mul_gen_if.sv
// Request/result bundle for add_shift_mul_gen: operands, sign modes and the
// ready/start/done handshake. The controller uses master, the multiplier uses slave.
interface add_shift_mul_gen_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 8
);
  logic             start;
  logic             sign_a;
  logic             sign_b;
  logic [N-1:0]     A;
  logic [M-1:0]     B;
  logic [N+M-1:0]   Y;
  logic             ready;
  logic             busy;
  logic             done;

  modport master (
    output start, sign_a, sign_b, A, B,
    input  Y, ready, busy, done
  );

  modport slave (
    input  start, sign_a, sign_b, A, B,
    output Y, ready, busy, done
  );
endinterface

// File: rtl/add_shift_mul_gen.sv
// Sequential N x M add-shift multiplier with per-operand signed/unsigned mode.
// Define MUL_EARLY_DONE_EN to finish immediately when either operand is zero.
module add_shift_mul_gen #(
  parameter int unsigned N    = 8,
  parameter int unsigned M    = 8,
  parameter int unsigned logN = 4
) (
  input logic                 clk,
  input logic                 rst,
  add_shift_mul_gen_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [logN-1:0] CntOne  = logN'(1);
  localparam logic [logN-1:0] CntLast = logN'(N);

  logic [1:0]      state_q, state_d;
  logic [N+M:0]    acc_q, acc_d;
  logic [logN-1:0] count_q, count_d;
  logic [N+M-1:0]  y_q, y_d;
  logic [M-1:0]    b_q, b_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;

  logic            last_step;
  logic            early;
  logic [M:0]      b_ext;
  logic [M+1:0]    hi_ext;
  logic [M+1:0]    addend;
  logic [M+1:0]    sum;
  logic [N+M:0]    acc_step;

  `ifdef MUL_EARLY_DONE_EN
  assign early = (bus.A == '0) || (bus.B == '0);
  `else
  assign early = 1'b0;
  `endif

  // The final step subtracts for a signed A: its MSB weighs -2^(N-1).
  always_comb begin
    last_step = (count_q == CntLast);
    b_ext     = acc_q[0] ? {sign_b_q & b_q[M-1], b_q} : '0;
    hi_ext    = {acc_q[N+M], acc_q[N+M:N]};
    addend    = {b_ext[M], b_ext};
    sum       = (last_step && sign_a_q) ? (hi_ext - addend) : (hi_ext + addend);
    acc_step  = {sum, acc_q[N-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    y_d      = y_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_a_d = bus.sign_a;
          sign_b_d = bus.sign_b;
          b_d      = bus.B;
          acc_d    = {{(M+1){1'b0}}, bus.A};
          count_d  = CntOne;
          if (early) begin
            state_d = DONE;
            y_d     = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = acc_step;
        if (last_step) begin
          state_d = DONE;
          y_d     = acc_step[N+M-1:0];
        end else begin
          count_d = count_q + CntOne;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      y_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      y_q      <= y_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end

  assign bus.Y     = y_q;
  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);

endmodule

// File: doc/add_shift_mul_gen.md
# add_shift_mul_gen

Parametrised sequential add-shift multiplier, N×M bits, one multiplier bit retired per clock. Each operand is independently selectable as signed (two's complement) or unsigned. A ready/start/done handshake lets a controller issue back-to-back products without the caller holding `start` for the whole operation. It sits beside the datapath arithmetic as a low-area multiplier for lab datapaths that need mixed-sign products.

## Interface
Parameters:
- `N`, default 8: multiplier (`A`) width, N ≥ 2
- `M`, default 8: multiplicand (`B`) width, M ≥ 2
- `logN`, default 4: counter width, must satisfy 2^logN > N

Ports:
- `clk`  in  1: single clock, all state updates on its rising edge
- `rst`  in  1: reset, synchronous and active-high
- `start`  in  1: request; accepted only when `ready`=1
- `sign_a`  in  1: 1 means `A` is two's complement, 0 means unsigned
- `sign_b`  in  1: 1 means `B` is two's complement, 0 means unsigned
- `A`  in  N: multiplier operand
- `B`  in  M: multiplicand operand
- `Y`  out  N+M: product, held until the next accepted `start`
- `ready`  out  1: block is idle and can accept `start`
- `busy`  out  1: operation in progress (= !ready)
- `done`  out  1: one-cycle pulse, `Y` valid for this operation

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE when count = N.
  - DONE → IDLE unconditionally.
- Accept edge (IDLE with `start`=1):
  - register `sign_a`, `sign_b` and `B`
  - ACC[N+M:N] ← 0, ACC[N-1:0] ← `A`
  - count ← 1
- The adder/subtractor is M+1 bits wide. Its B input is {`sign_b` & B[M-1], B}, masked to 0 when ACC[0]=0.
- RUN step for count = 1..N: ACC ← {sum[M+1:0], ACC[N-1:1]}, an arithmetic right shift of the partial product merged with the remaining multiplier bits.
  - When count = N and `sign_a`=1, the step subtracts instead of adds, because the MSB of A carries weight −2^(N-1).
  - Otherwise the step adds.
- Y ← ACC[N+M-1:0] on the RUN→DONE edge. Y is exact for all four sign combinations with no overflow.
- `start` is ignored in RUN and DONE. There is no queuing.
- Operand inputs are sampled only at the accept edge. Later changes have no effect.

## Timing
- Reset values: state=IDLE, `Y`=0, `ready`=1, `busy`=0, `done`=0, ACC=0, count=0.
- Latency: accept edge E0, RUN edges E1..EN. `done`=1 in the cycle following EN, which is N cycles after E0.
- `ready` returns to 1 one cycle after `done`. Maximum throughput is one product per N+2 cycles.
- `done` is high for exactly one cycle per accepted start.
- Reset has priority over everything. `rst` asserted in RUN or DONE aborts the operation the same edge: no `done` is produced and `Y` clears to 0.
- `start` and `rst` high together: reset wins and the request is dropped.

## Configuration
- `MUL_EARLY_DONE_EN` defined: at the accept edge, if `A`==0 or `B`==0, the FSM goes straight to DONE.
  - `Y` ← 0.
  - `done` pulses 1 cycle after the accept edge.
- `MUL_EARLY_DONE_EN` not defined: every operation takes the full N-cycle latency, including zero operands.

## Test plan
- Unsigned, N=M=8, A=255, B=255, sign_a=sign_b=0 → `done` 8 cycles after accept, Y=16'hFE01.
- Signed, A=8'h80 (−128), B=8'h80 (−128), sign_a=sign_b=1 → Y=16'h4000 (16384). Also A=−1, B=127 → Y=16'hFF81 (−127).
- Mixed signs: A=8'hFF signed (−1), B=8'hFF unsigned (255) → Y=16'hFF01 (−255). Then swap the modes (A unsigned 255, B signed −1) → same Y.
- Handshake: hold `start`=1 continuously for three products → exactly one accept per N+2 cycles. `start` pulses during RUN are ignored, and `Y` stays stable between `done` pulses.
- Reset mid-operation: assert `rst` at count=4 → next cycle Y=0, ready=1, busy=0, and no `done` pulse. A subsequent start with A=3, B=5 → Y=15.
- A=0, B=77: with `MUL_EARLY_DONE_EN`, `done` comes 1 cycle after accept with Y=0. Without it, `done` comes after 8 cycles with Y=0.
